// File: rtl/vga_rom_image_scaler.sv
// Places an IMG_W x IMG_H image from a synchronous ROM inside the VGA visible area.
// Supports power-of-two upscaling, chroma keying and a configurable ROM read latency.
module vga_rom_image_scaler #(
  parameter int CNT_W       = 32,
  parameter int IMG_W       = 600,
  parameter int IMG_H       = 500,
  parameter int ADDR_W      = 19,
  parameter int COLOR_W     = 4,
  parameter int ROM_LATENCY = 1,
  parameter int MAX_SHIFT   = 2,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                   pixel_clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       pixel_count,
  input  logic [CNT_W-1:0]       line_count,
  input  logic [CNT_W-1:0]       h_back_porch,
  input  logic [CNT_W-1:0]       v_back_porch,
  input  logic [CNT_W-1:0]       h_visible,
  input  logic [CNT_W-1:0]       v_visible,
  input  logic [CNT_W-1:0]       x_off,
  input  logic [CNT_W-1:0]       y_off,
  input  logic [1:0]             scale_shift,
  input  logic                   key_en,
  input  logic [3*COLOR_W-1:0]   key_color,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic                   rom_en,
  input  logic [3*COLOR_W-1:0]   rom_data,
  output logic [COLOR_W-1:0]     red_out,
  output logic [COLOR_W-1:0]     grn_out,
  output logic [COLOR_W-1:0]     blu_out,
  output logic                   pixel_valid,
  output logic                   frame_done
);

  localparam int RGB_W  = 3 * COLOR_W;
  localparam int SUB_W  = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;
  localparam int WIDE_W = CNT_W + MAX_SHIFT + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    x_off_q, x_off_d, y_off_q, y_off_d;
  logic [1:0]          shift_q, shift_d;
  logic                key_en_q, key_en_d;
  logic [RGB_W-1:0]    key_color_q, key_color_d;
  logic [ADDR_W-1:0]   col_q, col_d, row_base_q, row_base_d, rom_addr_q, rom_addr_d;
  logic [SUB_W-1:0]    hsub_q, hsub_d, vsub_q, vsub_d;
  logic                h_win_prev_q, h_win_prev_d;
  logic                rom_en_q, rom_en_d;
  logic                frame_done_q, frame_done_d;
  logic [ROM_LATENCY:0] win_pipe_q, win_pipe_d;

  logic                frame_start, h_win, v_win, h_rise, h_fall, show;
  logic [WIDE_W-1:0]   sw, sh, h_start, h_end, v_start, v_end, h_vis_end, v_vis_end;
  logic [ADDR_W-1:0]   col_eff;
  logic [SUB_W-1:0]    hsub_eff, sub_max;

  // Window bounds are computed wide so offset + scaled size can never wrap.
  always_comb begin
    frame_start = (pixel_count == '0) && (line_count == '0);
    sw          = WIDE_W'(IMG_W) << shift_q;
    sh          = WIDE_W'(IMG_H) << shift_q;
    h_start     = WIDE_W'(h_back_porch) + WIDE_W'(x_off_q);
    v_start     = WIDE_W'(v_back_porch) + WIDE_W'(y_off_q);
    h_vis_end   = WIDE_W'(h_back_porch) + WIDE_W'(h_visible);
    v_vis_end   = WIDE_W'(v_back_porch) + WIDE_W'(v_visible);
    h_end       = ((h_start + sw) < h_vis_end) ? (h_start + sw) : h_vis_end;
    v_end       = ((v_start + sh) < v_vis_end) ? (v_start + sh) : v_vis_end;
    h_win       = (WIDE_W'(pixel_count) >= h_start) && (WIDE_W'(pixel_count) < h_end);
    v_win       = (WIDE_W'(line_count) >= v_start) && (WIDE_W'(line_count) < v_end);
    sub_max     = SUB_W'((32'd1 << shift_q) - 32'd1);
    h_rise      = h_win && !h_win_prev_q;
    h_fall      = !h_win && h_win_prev_q;
    col_eff     = h_rise ? '0 : col_q;
    hsub_eff    = h_rise ? '0 : hsub_q;
  end

  always_comb begin
    state_d      = state_q;
    x_off_d      = x_off_q;
    y_off_d      = y_off_q;
    shift_d      = shift_q;
    key_en_d     = key_en_q;
    key_color_d  = key_color_q;
    col_d        = col_eff;
    hsub_d       = hsub_eff;
    row_base_d   = row_base_q;
    vsub_d       = vsub_q;
    h_win_prev_d = h_win;
    rom_en_d     = h_win && v_win && enable && (state_q == ACTIVE);
    rom_addr_d   = row_base_q + col_eff;
    frame_done_d = 1'b0;
    win_pipe_d   = {win_pipe_q[ROM_LATENCY-1:0], rom_en_d};

    if (h_win && v_win) begin
      if (hsub_eff == sub_max) begin
        hsub_d = '0;
        col_d  = col_eff + ADDR_W'(1);
      end else begin
        hsub_d = hsub_eff + SUB_W'(1);
      end
    end

    if (h_fall && v_win) begin
      if (vsub_q == sub_max) begin
        vsub_d     = '0;
        row_base_d = row_base_q + ROW_STEP;
      end else begin
        vsub_d = vsub_q + SUB_W'(1);
      end
    end

    if (rom_en_d && (rom_addr_d == LAST_ADDR) && (hsub_eff == sub_max) && (vsub_q == sub_max)) begin
      frame_done_d = 1'b1;
      state_d      = DONE;
    end

    // A frame start always rearms addressing, so a finished frame moves straight on to the next one.
    if (frame_start) begin
      x_off_d     = x_off;
      y_off_d     = y_off;
      shift_d     = (scale_shift > 2'(MAX_SHIFT)) ? 2'(MAX_SHIFT) : scale_shift;
      key_en_d    = key_en;
      key_color_d = key_color;
      col_d       = '0;
      hsub_d      = '0;
      row_base_d  = '0;
      vsub_d      = '0;
      rom_addr_d  = '0;
      state_d     = enable ? ACTIVE : WAIT_FRAME;
    end

    if (!enable) state_d = WAIT_FRAME;
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_FRAME;
      x_off_q      <= '0;
      y_off_q      <= '0;
      shift_q      <= '0;
      key_en_q     <= 1'b0;
      key_color_q  <= '0;
      col_q        <= '0;
      hsub_q       <= '0;
      row_base_q   <= '0;
      vsub_q       <= '0;
      h_win_prev_q <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      frame_done_q <= 1'b0;
      win_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      x_off_q      <= x_off_d;
      y_off_q      <= y_off_d;
      shift_q      <= shift_d;
      key_en_q     <= key_en_d;
      key_color_q  <= key_color_d;
      col_q        <= col_d;
      hsub_q       <= hsub_d;
      row_base_q   <= row_base_d;
      vsub_q       <= vsub_d;
      h_win_prev_q <= h_win_prev_d;
      rom_en_q     <= rom_en_d;
      rom_addr_q   <= rom_addr_d;
      frame_done_q <= frame_done_d;
      win_pipe_q   <= win_pipe_d;
    end
  end

  // The last pipeline stage lines up with the ROM word read for the same pixel.
  assign show     = win_pipe_q[ROM_LATENCY] && !(key_en_q && (rom_data == key_color_q));
  assign {red_out, grn_out, blu_out} = show ? rom_data : BG_COLOR;
  assign pixel_valid = show;
  assign rom_addr    = rom_addr_q;
  assign rom_en      = rom_en_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_vga_rom_image_scaler.sv
// Directed bench for vga_rom_image_scaler: 4x2 image, 20x12 raster, ROM word equal to its address.
module tb_vga_rom_image_scaler;
  localparam int CNT_W = 16;
  localparam int HT = 20;
  localparam int VT = 12;
  localparam logic [11:0] BG = 12'hABC;

  logic              pixel_clock = 1'b0;
  logic              reset_n, enable, key_en;
  logic [CNT_W-1:0]  pixel_count, line_count, h_back_porch, v_back_porch;
  logic [CNT_W-1:0]  h_visible, v_visible, x_off, y_off;
  logic [1:0]        scale_shift;
  logic [11:0]       key_color, rom_data;
  logic [2:0]        rom_addr;
  logic              rom_en, pixel_valid, frame_done;
  logic [3:0]        red_out, grn_out, blu_out;

  int total = 0;
  int bad = 0;
  int hook_kind = 0;
  int hook_line = 0;
  int hook_px = 0;
  int done_cnt;

  logic [2:0]  addr_log  [VT][HT];
  logic        en_log    [VT][HT];
  logic        valid_log [VT][HT];
  logic        done_log  [VT][HT];
  logic [11:0] col_log   [VT][HT];

  always #5 pixel_clock = ~pixel_clock;

  initial rom_data = '0;
  always @(posedge pixel_clock) if (rom_en) rom_data <= {9'd0, rom_addr};

  vga_rom_image_scaler #(
    .CNT_W(CNT_W), .IMG_W(4), .IMG_H(2), .ADDR_W(3), .COLOR_W(4),
    .ROM_LATENCY(1), .MAX_SHIFT(2), .BG_COLOR(BG)
  ) dut (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .enable(enable),
    .pixel_count(pixel_count), .line_count(line_count),
    .h_back_porch(h_back_porch), .v_back_porch(v_back_porch),
    .h_visible(h_visible), .v_visible(v_visible),
    .x_off(x_off), .y_off(y_off), .scale_shift(scale_shift),
    .key_en(key_en), .key_color(key_color),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .red_out(red_out), .grn_out(grn_out), .blu_out(blu_out),
    .pixel_valid(pixel_valid), .frame_done(frame_done)
  );

  // One full raster; outputs are logged mid-cycle for every (line, pixel).
  task run_frame();
    done_cnt = 0;
    for (int ln = 0; ln < VT; ln++) begin
      for (int px = 0; px < HT; px++) begin
        pixel_count = CNT_W'(px);
        line_count  = CNT_W'(ln);
        if (hook_kind == 1 && ln == hook_line && px == hook_px) x_off = 1;
        if (hook_kind == 2 && ln == hook_line && px == hook_px) reset_n = 1'b0;
        if (hook_kind == 2 && ln == hook_line && px == hook_px + 4) reset_n = 1'b1;
        @(negedge pixel_clock);
        addr_log[ln][px]  = rom_addr;
        en_log[ln][px]    = rom_en;
        valid_log[ln][px] = pixel_valid;
        done_log[ln][px]  = frame_done;
        col_log[ln][px]   = {red_out, grn_out, blu_out};
        if (frame_done) done_cnt++;
        @(posedge pixel_clock);
        #1;
      end
    end
  endtask

  task test_reset();
    reset_n = 1'b0; enable = 1'b1; key_en = 1'b0; key_color = 12'd3;
    h_back_porch = 10; v_back_porch = 5; h_visible = 8; v_visible = 6;
    x_off = 0; y_off = 0; scale_shift = 2'd0;
    pixel_count = CNT_W'(HT - 1); line_count = CNT_W'(VT - 1);
    repeat (3) @(posedge pixel_clock);
    #1;
    total++;
    if (rom_en !== 1'b0 || rom_addr !== 3'd0) begin
      bad++; $display("FAIL reset_rom en=%b addr=%0d want en=0 addr=0", rom_en, rom_addr);
    end
    total++;
    if ({red_out, grn_out, blu_out} !== BG || pixel_valid !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL reset_out col=%h valid=%b done=%b want col=%h valid=0 done=0",
                      {red_out, grn_out, blu_out}, pixel_valid, frame_done, BG);
    end
    reset_n = 1'b1;
  endtask

  task test_basic();
    run_frame();
    for (int p = 0; p < 4; p++) begin
      total++;
      if (en_log[5][11+p] !== 1'b1 || addr_log[5][11+p] !== 3'(p)) begin
        bad++; $display("FAIL basic_addr p%0d en=%b addr=%0d want en=1 addr=%0d",
                        11+p, en_log[5][11+p], addr_log[5][11+p], p);
      end
      total++;
      if (col_log[5][12+p] !== 12'(p) || valid_log[5][12+p] !== 1'b1) begin
        bad++; $display("FAIL basic_col p%0d col=%h valid=%b want col=%h valid=1",
                        12+p, col_log[5][12+p], valid_log[5][12+p], 12'(p));
      end
    end
    total++;
    if (en_log[5][15] !== 1'b0 || col_log[5][16] !== BG || valid_log[5][16] !== 1'b0) begin
      bad++; $display("FAIL basic_edge en=%b col=%h valid=%b want en=0 col=%h valid=0",
                      en_log[5][15], col_log[5][16], valid_log[5][16], BG);
    end
    total++;
    if (col_log[6][12] !== 12'd4) begin
      bad++; $display("FAIL basic_row1 col=%h want 004", col_log[6][12]);
    end
    total++;
    if (done_log[6][14] !== 1'b1 || addr_log[6][14] !== 3'd7 || done_cnt != 1) begin
      bad++; $display("FAIL basic_done done=%b addr=%0d pulses=%0d want done=1 addr=7 pulses=1",
                      done_log[6][14], addr_log[6][14], done_cnt);
    end
  endtask

  task test_scale();
    int errs;
    scale_shift = 2'd1;
    run_frame();
    errs = 0;
    for (int ln = 5; ln < 9; ln++) begin
      for (int p = 0; p < 8; p++) begin
        if (en_log[ln][11+p] !== 1'b1 || addr_log[ln][11+p] !== 3'(((ln - 5) / 2) * 4 + p / 2)) errs++;
        if (col_log[ln][12+p] !== 12'(((ln - 5) / 2) * 4 + p / 2)) errs++;
      end
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL scale_map wrong_entries=%0d want 0", errs);
    end
    total++;
    if (done_log[8][18] !== 1'b1 || addr_log[8][18] !== 3'd7 || done_cnt != 1) begin
      bad++; $display("FAIL scale_done done=%b addr=%0d pulses=%0d want done=1 addr=7 pulses=1",
                      done_log[8][18], addr_log[8][18], done_cnt);
    end
    scale_shift = 2'd0;
  endtask

  task test_clip();
    x_off = 2; h_visible = 4;
    run_frame();
    total++;
    if (addr_log[5][13] !== 3'd0 || addr_log[5][14] !== 3'd1 || en_log[5][15] !== 1'b0) begin
      bad++; $display("FAIL clip_line5 a13=%0d a14=%0d en15=%b want 0 1 0",
                      addr_log[5][13], addr_log[5][14], en_log[5][15]);
    end
    total++;
    if (col_log[6][14] !== 12'd4 || col_log[6][15] !== 12'd5 || col_log[6][16] !== BG) begin
      bad++; $display("FAIL clip_line6 c14=%h c15=%h c16=%h want 004 005 %h",
                      col_log[6][14], col_log[6][15], col_log[6][16], BG);
    end
    total++;
    if (done_cnt != 0) begin
      bad++; $display("FAIL clip_done pulses=%0d want 0", done_cnt);
    end
    x_off = 0; h_visible = 8;
  endtask

  task test_key();
    key_en = 1'b1;
    run_frame();
    total++;
    if (col_log[5][15] !== BG || valid_log[5][15] !== 1'b0) begin
      bad++; $display("FAIL key_hit col=%h valid=%b want col=%h valid=0", col_log[5][15], valid_log[5][15], BG);
    end
    total++;
    if (col_log[5][14] !== 12'd2 || valid_log[5][14] !== 1'b1 || col_log[6][15] !== 12'd7) begin
      bad++; $display("FAIL key_miss c14=%h v14=%b c6_15=%h want 002 1 007",
                      col_log[5][14], valid_log[5][14], col_log[6][15]);
    end
    key_en = 1'b0;
  endtask

  task test_midframe_offset();
    hook_kind = 1; hook_line = 3; hook_px = 0;
    run_frame();
    hook_kind = 0;
    total++;
    if (en_log[5][11] !== 1'b1 || addr_log[5][11] !== 3'd0 || col_log[5][12] !== 12'd0) begin
      bad++; $display("FAIL mid_current en=%b addr=%0d col=%h want 1 0 000",
                      en_log[5][11], addr_log[5][11], col_log[5][12]);
    end
    run_frame();
    total++;
    if (en_log[5][11] !== 1'b0 || en_log[5][12] !== 1'b1 || addr_log[5][12] !== 3'd0) begin
      bad++; $display("FAIL mid_next_addr en11=%b en12=%b addr12=%0d want 0 1 0",
                      en_log[5][11], en_log[5][12], addr_log[5][12]);
    end
    total++;
    if (col_log[5][13] !== 12'd0 || col_log[5][16] !== 12'd3 || done_log[6][15] !== 1'b1) begin
      bad++; $display("FAIL mid_next_col c13=%h c16=%h done=%b want 000 003 1",
                      col_log[5][13], col_log[5][16], done_log[6][15]);
    end
    x_off = 0;
  endtask

  task test_reset_midframe();
    int en_seen;
    hook_kind = 2; hook_line = 6; hook_px = 11;
    run_frame();
    hook_kind = 0;
    total++;
    if (en_log[6][11] !== 1'b0 || addr_log[6][11] !== 3'd0 || col_log[6][11] !== BG || valid_log[6][11] !== 1'b0) begin
      bad++; $display("FAIL rst_mid en=%b addr=%0d col=%h valid=%b want 0 0 %h 0",
                      en_log[6][11], addr_log[6][11], col_log[6][11], valid_log[6][11], BG);
    end
    en_seen = 0;
    for (int ln = 6; ln < VT; ln++)
      for (int px = 0; px < HT; px++)
        if ((ln > 6 || px >= 11) && en_log[ln][px] !== 1'b0) en_seen++;
    total++;
    if (en_seen != 0 || done_cnt != 0) begin
      bad++; $display("FAIL rst_rest en_cycles=%0d pulses=%0d want 0 0", en_seen, done_cnt);
    end
    run_frame();
    total++;
    if (en_log[5][11] !== 1'b1 || addr_log[5][11] !== 3'd0 || col_log[5][12] !== 12'd0 || done_cnt != 1) begin
      bad++; $display("FAIL rst_restart en=%b addr=%0d col=%h pulses=%0d want 1 0 000 1",
                      en_log[5][11], addr_log[5][11], col_log[5][12], done_cnt);
    end
  endtask

  task test_enable();
    int en_seen;
    int valid_seen;
    enable = 1'b0;
    run_frame();
    en_seen = 0; valid_seen = 0;
    for (int ln = 0; ln < VT; ln++)
      for (int px = 0; px < HT; px++) begin
        if (en_log[ln][px] !== 1'b0) en_seen++;
        if (valid_log[ln][px] !== 1'b0 || col_log[ln][px] !== BG) valid_seen++;
      end
    total++;
    if (en_seen != 0 || valid_seen != 0 || done_cnt != 0) begin
      bad++; $display("FAIL enable_off en_cycles=%0d image_cycles=%0d pulses=%0d want 0 0 0",
                      en_seen, valid_seen, done_cnt);
    end
    enable = 1'b1;
    run_frame();
    total++;
    if (en_log[5][11] !== 1'b1 || addr_log[5][11] !== 3'd0 || done_cnt != 1) begin
      bad++; $display("FAIL enable_on en=%b addr=%0d pulses=%0d want 1 0 1",
                      en_log[5][11], addr_log[5][11], done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_scale();
    test_clip();
    test_key();
    test_midframe_offset();
    test_reset_midframe();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
